// File: rtl/ppf_pkg.sv
// Shared constants, types and prototype coefficients for the 8-channel polyphase filter bank.
package ppf_pkg;

  localparam int unsigned NUM_CH          = 8;
  localparam int unsigned PPF_TAPS_PER_CH = 4;
  localparam int unsigned PPF_COEF_WIDTH  = 16;
  localparam int unsigned PPF_TDATA_WIDTH = 32;
  localparam int unsigned PPF_PROTO_LEN   = NUM_CH * PPF_TAPS_PER_CH;

  typedef logic signed [PPF_COEF_WIDTH-1:0]  coef_t;
  typedef logic signed [PPF_TDATA_WIDTH-1:0] sample_t;

  // Q1.15 Hamming-windowed sinc low-pass, cutoff pi/8, symmetric about 15.5.
  localparam coef_t PPF_COEF [PPF_PROTO_LEN] = '{
    -16'sd11,   -16'sd36,   -16'sd75,   -16'sd133,
    -16'sd198,  -16'sd245,  -16'sd232,  -16'sd113,
     16'sd153,   16'sd584,   16'sd1171,  16'sd1868,
     16'sd2599,  16'sd3268,  16'sd3782,  16'sd4068,
     16'sd4068,  16'sd3782,  16'sd3268,  16'sd2599,
     16'sd1868,  16'sd1171,  16'sd584,   16'sd153,
    -16'sd113,  -16'sd232,  -16'sd245,  -16'sd198,
    -16'sd133,  -16'sd75,   -16'sd36,   -16'sd11
  };

endpackage

// File: rtl/ppf_branch.sv
// One polyphase branch: tapped delay line plus multiply-accumulate against h[8k+P].
module ppf_branch
  import ppf_pkg::*;
#(
  parameter int unsigned P           = 0,
  parameter int unsigned TAPS        = PPF_TAPS_PER_CH,
  parameter int unsigned TDATA_WIDTH = PPF_TDATA_WIDTH,
  parameter int unsigned COEF_WIDTH  = PPF_COEF_WIDTH,
  parameter int unsigned ACC_W       = TDATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          shift_en,
  input  logic signed [TDATA_WIDTH-1:0] sample,
  output logic signed [ACC_W-1:0]       y_c
);

  localparam int unsigned PROD_W = TDATA_WIDTH + COEF_WIDTH;

  logic signed [TDATA_WIDTH-1:0] dl_q [TAPS];
  logic signed [PROD_W-1:0]      prod [TAPS];

  // Delay line: newest sample enters at index 0, oldest falls off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) dl_q[k] <= '0;
    end else if (shift_en) begin
      dl_q[0] <= sample;
      for (int k = 1; k < TAPS; k++) dl_q[k] <= dl_q[k-1];
    end
  end

  // Exact signed products, one per tap.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign prod[k] = PROD_W'(dl_q[k]) * PROD_W'(PPF_COEF[NUM_CH*k + P]);
  end

  // Sign-extended sum of the tap products; width leaves headroom for every tap.
  always_comb begin
    y_c = '0;
    for (int k = 0; k < TAPS; k++) y_c = y_c + ACC_W'(prod[k]);
  end

endmodule

// File: rtl/s_axis_direct_ppf.sv
// AXI4-Stream slave front end, commutator and output registers for the 8-branch polyphase filter.
module s_axis_direct_ppf
  import ppf_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TAPS_PER_CH = PPF_TAPS_PER_CH,
  parameter int unsigned COEF_WIDTH  = PPF_COEF_WIDTH,
  parameter int unsigned OUT_WIDTH   = 64
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [TDATA_WIDTH-1:0]      TDATA,
  input  logic                        TVALID,
  input  logic                        TLAST,
  output logic                        TREADY,
  output logic signed [OUT_WIDTH-1:0] channel0_data_o,
  output logic signed [OUT_WIDTH-1:0] channel1_data_o,
  output logic signed [OUT_WIDTH-1:0] channel2_data_o,
  output logic signed [OUT_WIDTH-1:0] channel3_data_o,
  output logic signed [OUT_WIDTH-1:0] channel4_data_o,
  output logic signed [OUT_WIDTH-1:0] channel5_data_o,
  output logic signed [OUT_WIDTH-1:0] channel6_data_o,
  output logic signed [OUT_WIDTH-1:0] channel7_data_o
);

  localparam int unsigned CNT_W  = $clog2(NUM_CH);
  localparam int unsigned ACC_W  = TDATA_WIDTH + COEF_WIDTH + $clog2(TAPS_PER_CH);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

  logic                        tready_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        upd_q;
  logic                        accept_c;
  logic signed [ACC_W-1:0]     y_c   [NUM_CH];
  logic signed [OUT_WIDTH-1:0] out_q [NUM_CH];

  assign accept_c = TVALID & tready_q;
  assign TREADY   = tready_q;

  // Ready rises on the first edge after reset and never drops; no back-pressure.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) tready_q <= 1'b0;
    else          tready_q <= 1'b1;
  end

  // Commutator: advance per accepted beat, realign to branch 0 on TLAST; flag complete blocks.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q <= '0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= accept_c && (cnt_q == LAST_CH);
      if (accept_c) begin
        if (TLAST || cnt_q == LAST_CH) cnt_q <= '0;
        else                           cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar p = 0; p < NUM_CH; p++) begin : g_branch
    ppf_branch #(
      .P           (p),
      .TAPS        (TAPS_PER_CH),
      .TDATA_WIDTH (TDATA_WIDTH),
      .COEF_WIDTH  (COEF_WIDTH),
      .ACC_W       (ACC_W)
    ) u_branch (
      .clk      (ACLK),
      .rst_n    (ARESETn),
      .shift_en (accept_c && (cnt_q == CNT_W'(p))),
      .sample   ($signed(TDATA)),
      .y_c      (y_c[p])
    );
  end

  // Capture all branch results together one cycle after the block-completing beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_CH; i++) out_q[i] <= '0;
    end else if (upd_q) begin
      for (int i = 0; i < NUM_CH; i++) out_q[i] <= OUT_WIDTH'(y_c[i]);
    end
  end

  assign channel0_data_o = out_q[0];
  assign channel1_data_o = out_q[1];
  assign channel2_data_o = out_q[2];
  assign channel3_data_o = out_q[3];
  assign channel4_data_o = out_q[4];
  assign channel5_data_o = out_q[5];
  assign channel6_data_o = out_q[6];
  assign channel7_data_o = out_q[7];

endmodule

// File: tb/tb_s_axis_direct_ppf.sv
// Directed self-checking bench for the 8-channel polyphase filter bank.
module tb_s_axis_direct_ppf;

  logic        clk;
  logic        rst_n;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic signed [63:0] ch [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed branch sums h[p]+h[8+p]+h[16+p]+h[24+p].
  localparam longint SUM_H [8] = '{64'sd4097, 64'sd4098, 64'sd4119, 64'sd4136,
                                   64'sd4136, 64'sd4119, 64'sd4098, 64'sd4097};
  // Channel 0 response to a 2 on beat 0: 2h[0], 2h[8], 2h[16], 2h[24], 0.
  localparam longint IMP0 [5] = '{-64'sd22, 64'sd306, 64'sd8136, -64'sd226, 64'sd0};

  s_axis_direct_ppf dut (
    .ACLK            (clk),
    .ARESETn         (rst_n),
    .TDATA           (tdata),
    .TVALID          (tvalid),
    .TLAST           (tlast),
    .TREADY          (tready),
    .channel0_data_o (ch[0]),
    .channel1_data_o (ch[1]),
    .channel2_data_o (ch[2]),
    .channel3_data_o (ch[3]),
    .channel4_data_o (ch[4]),
    .channel5_data_o (ch[5]),
    .channel6_data_o (ch[6]),
    .channel7_data_o (ch[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // One beat; optional idle cycle first. Returns 1 time unit after the accepting edge.
  task automatic drive_beat(input logic [31:0] d, input logic l, input bit gap);
    int w;
    if (gap) begin
      @(negedge clk);
      tvalid = 1'b0;
    end
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    w = 0;
    while (!tready && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (w >= 16) check("tready_timeout", 64'(tready), 64'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] d, input bit gap);
    for (int i = 0; i < 8; i++) drive_beat(d, 1'b0, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    tdata  = '0;
    tvalid = 1'b0;
    tlast  = 1'b0;

    // Reset state.
    #200;
    check("reset_tready", 64'(tready), 64'd0);
    for (int p = 0; p < 8; p++) check($sformatf("reset_ch%0d", p), ch[p], 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("tready_after_release", 64'(tready), 64'd1);

    // Impulse on branch 0, five blocks; update lands one cycle after the 8th beat.
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) drive_beat((b == 0 && i == 0) ? 32'd2 : 32'd0, 1'b0, 1'b0);
      check($sformatf("imp_pre_b%0d", b), ch[0], (b == 0) ? 64'd0 : 64'(IMP0[b-1]));
      @(posedge clk);
      #1;
      check($sformatf("imp_post_b%0d", b), ch[0], 64'(IMP0[b]));
    end
    for (int p = 1; p < 8; p++) check($sformatf("imp_ch%0d_zero", p), ch[p], 64'd0);

    // DC input of 1, back to back.
    do_reset();
    for (int b = 0; b < 5; b++) begin
      send_block(32'd1, 1'b0);
      @(posedge clk);
      #1;
      if (b >= 3)
        for (int p = 0; p < 8; p++) check($sformatf("dc_b%0d_ch%0d", b, p), ch[p], 64'(SUM_H[p]));
    end

    // Most negative sample: -2^31 * sum, sign-extended to 64 bits.
    do_reset();
    for (int b = 0; b < 4; b++) send_block(32'h8000_0000, 1'b0);
    @(posedge clk);
    #1;
    for (int p = 0; p < 8; p++)
      check($sformatf("neg_ch%0d", p), ch[p], 64'(-(64'sd1 <<< 31) * SUM_H[p]));

    // DC with TVALID gaps; first block gives h[p] alone.
    do_reset();
    for (int b = 0; b < 5; b++) begin
      send_block(32'd1, 1'b1);
      if (b == 0) check("gap_pre_b0_ch0", ch[0], 64'd0);
      @(posedge clk);
      #1;
      if (b == 0) begin
        check("gap_post_b0_ch0", ch[0], -64'sd11);
        check("gap_post_b0_ch7", ch[7], -64'sd113);
      end
      if (b >= 3)
        for (int p = 0; p < 8; p += 3) check($sformatf("gap_b%0d_ch%0d", b, p), ch[p], 64'(SUM_H[p]));
    end

    // TLAST on beat 4: no update, next beat realigns to branch 0.
    do_reset();
    for (int i = 0; i < 5; i++) drive_beat(32'd1, (i == 4), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("tlast_no_upd_ch0", ch[0], 64'd0);
    check("tlast_no_upd_ch4", ch[4], 64'd0);
    send_block(32'd2, 1'b0);
    @(posedge clk);
    #1;
    check("tlast_ch0", ch[0], 64'sd131);    // 2h[0] + h[8]
    check("tlast_ch4", ch[4], 64'sd2203);   // 2h[4] + h[12]
    check("tlast_ch5", ch[5], -64'sd490);   // 2h[5]

    // Asynchronous reset mid-block clears outputs at once and restarts at branch 0.
    for (int i = 0; i < 3; i++) drive_beat(32'd5, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ch0", ch[0], 64'd0);
    check("midrst_ch4", ch[4], 64'd0);
    check("midrst_tready", 64'(tready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_block(32'd1, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_after_ch0", ch[0], -64'sd11);
    check("midrst_after_ch3", ch[3], -64'sd133);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s_axis_direct_ppf.md
Name: s_axis_direct_ppf

Overview:
- 8-channel direct-form (polyphase-decomposed) FIR filter bank with decimation by 8.
- Input is a single AXI4-Stream slave of real signed samples; output is 8 parallel signed subfilter results, one per branch.
- Sits between a sample source (ADC/DMA stream) and a downstream channel combiner/DFT stage.
- No DFT is performed inside this block.

Parameters:
- TDATA_WIDTH, 32, width of TDATA; sample is signed two's complement of this width.
- TAPS_PER_CH, 4, taps per polyphase branch; the prototype length is 8*TAPS_PER_CH.
- COEF_WIDTH, 16, signed Q1.15 coefficient width.
- OUT_WIDTH, 64, channel output width.

Ports:
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- TDATA  in  TDATA_WIDTH  input sample.
- TVALID  in  1  sample valid.
- TLAST  in  1  block-end marker, used for realignment.
- TREADY  out  1  slave ready.
- channel0_data_o … channel7_data_o  out  OUT_WIDTH each, signed; branch p filter output.

Behaviour:
- Reset (ARESETn=0, asynchronous):
  - TREADY=0.
  - All channel outputs = 0.
  - Commutator counter = 0.
  - All delay lines = 0.
  - Reset asserted mid-block discards the partial block.
- After reset release:
  - TREADY=1 from the first rising edge after deassertion, and stays 1; the block never back-pressures.
  - A beat is accepted on a rising edge with TVALID&TREADY. With TVALID=0, no state changes.
- Commutator:
  - 3-bit counter c. An accepted beat is shifted into branch c's delay line (newest at index 0; oldest dropped).
  - c then increments, wrapping 7→0.
- TLAST:
  - An accepted beat with TLAST=1 is processed normally, then c is forced to 0.
  - If that beat had c≠7, the block is incomplete: outputs are not updated, and delay-line contents are kept.
- Computation:
  - y_p = Σ_{k=0..TAPS_PER_CH-1} h[8k+p] · x_p[k], where x_p[k] is the k-th newest sample in branch p.
  - h is the package prototype.
- Width rules:
  - Products are 48-bit signed.
  - The sum is 50-bit signed, sign-extended to OUT_WIDTH.
  - No saturation or rounding; overflow is impossible.
- Timing:
  - The 8th beat of a block (c=7) is accepted at edge E. All 8 outputs update together at edge E+1.
  - Outputs are registered and hold their value until the next complete block.
  - A back-to-back stream yields one output update every 8 accepted beats.
- Gaps in TVALID inside a block are allowed; timing is counted from the accepting edge of the 8th beat.

Decomposition:
- Package ppf_pkg holds:
  - NUM_CH=8.
  - Default TAPS_PER_CH.
  - COEF_WIDTH.
  - Prototype coefficient array PPF_COEF[0..31] (signed Q1.15 windowed-sinc low-pass, cutoff π/8).
  - A typedef for the coefficient type and for the sample type.
- One sub-module, ppf_branch, is natural: one delay line plus MAC for a single branch, parameterised by branch index p. Instantiate it 8 times with a generate loop.
- The top level contains the AXI handshake, commutator, TLAST handling and output registers.

Test Plan:
- Reset check: hold ARESETn=0 for 200 ns, then release. During reset, TREADY=0 and all outputs =0. TREADY=1 by the second ACLK edge after release.
- Impulse on branch 0: send TDATA=2 on beat 0, then 0 for beats 1..39 (5 blocks).
  - channel0 shows 2·h[0], 2·h[8], 2·h[16], 2·h[24], then 0 over successive blocks.
  - channels 1–7 stay 0.
  - Each update occurs one cycle after the c=7 beat.
- DC input: drive TDATA=1 continuously for 40 beats. After the 4th block, channel p = Σ_k h[8k+p] for all p and stays constant.
- Sign/width: drive TDATA=0x80000000 on all beats. After 4 blocks, channel p = −2^31·Σ_k h[8k+p], sign-extended correctly to 64 bits.
- Handshake gaps: repeat the DC test with TVALID toggled every other cycle. Results are identical, and updates land one cycle after each 8th accepted beat.
- TLAST realignment: send 5 beats with TLAST on beat 4. No output update occurs, and the next beat is written to branch 0. A reset pulse mid-block clears all outputs and the counter immediately.
